// File: rtl/sa_systolic_array_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
// Optional build macro: SA_SATURATE_EN (clamp results instead of wrapping).
package sa_systolic_array_pkg;

  // One-hot controller state encoding
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_FEED  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  // Widest accumulator the result reduction ever has to handle
  localparam int unsigned SAT_W = 128;

  // Accumulator width that cannot overflow over m signed products
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned m);
    return 2 * dw + 32'($clog2(m)) + 1;
  endfunction

  // Drop fractional bits (floor), then clamp or leave for wrap-by-truncation
  function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] acc,
                                                        input int unsigned dw,
                                                        input int unsigned frac);
    logic signed [SAT_W-1:0] sh;
`ifdef SA_SATURATE_EN
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
`endif
    sh = acc >>> frac;
`ifdef SA_SATURATE_EN
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (sh > hi) begin
      sh = hi;
    end else if (sh < lo) begin
      sh = lo;
    end
`endif
    return sh;
  endfunction

endpackage

// File: rtl/sa_systolic_array_pe.sv
// One multiply-accumulate processing element with registered x/w pass-through.
module sa_pe
  import sa_systolic_array_pkg::*;
#(
  parameter int unsigned D_W   = 16,
  parameter int unsigned ACC_W = 37
) (
  input  logic                    I_CLK,
  input  logic                    I_ASYN_RSTN,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [D_W-1:0]   x_i,
  input  logic signed [D_W-1:0]   w_i,
  output logic signed [D_W-1:0]   x_o,
  output logic signed [D_W-1:0]   w_o,
  output logic signed [ACC_W-1:0] acc_nxt_c
);

  localparam int unsigned P_W = 2 * D_W;

  logic signed [D_W-1:0]   x_q;
  logic signed [D_W-1:0]   w_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [P_W-1:0]   prod_c;

  // Full-precision product and the accumulator value after this edge
  always_comb begin
    prod_c    = P_W'(x_i) * P_W'(w_i);
    acc_nxt_c = en_i ? (acc_q + ACC_W'(prod_c)) : acc_q;
  end

  // Accumulate and forward operands on each shift edge; clear wins
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      x_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      x_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      x_q   <= x_i;
      w_q   <= w_i;
      acc_q <= acc_nxt_c;
    end
  end

  assign x_o = x_q;
  assign w_o = w_q;

endmodule

// File: rtl/sa_systolic_array.sv
// Output-stationary signed fixed-point systolic array computing X*W.
// Optional build macro: SA_SATURATE_EN (saturate results instead of wrapping).
module sa_systolic_array
  import sa_systolic_array_pkg::*;
#(
  parameter int unsigned D_W   = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned X_R   = 16,
  parameter int unsigned M_DIM = 16,
  parameter int unsigned W_C   = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_ASYN_RSTN,
  input  logic                  I_SYNC_RSTN,
  input  logic                  I_START,
  input  logic signed [D_W-1:0] I_X_VECTOR [0:X_R-1],
  input  logic signed [D_W-1:0] I_W_VECTOR [0:W_C-1],
  output logic                  O_PE_SHIFT,
  output logic                  O_BUSY,
  output logic                  O_VALID,
  output logic signed [D_W-1:0] O_RESULT [0:X_R-1][0:W_C-1]
);

  localparam int unsigned ACC_W   = acc_width(D_W, M_DIM);
  localparam int unsigned DRAIN_N = X_R + W_C - 2;
  localparam int unsigned CNT_MAX = (M_DIM > DRAIN_N) ? M_DIM : DRAIN_N;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               start_clr_c;
  logic               pe_clr_c;
  logic               en_c;
  logic               cap_c;

  logic signed [D_W-1:0]   x_feed_c [0:X_R-1];
  logic signed [D_W-1:0]   w_feed_c [0:W_C-1];
  logic signed [D_W-1:0]   x_link   [0:X_R-1][0:W_C-1];
  logic signed [D_W-1:0]   w_link   [0:X_R-1][0:W_C-1];
  logic signed [ACC_W-1:0] acc_nxt  [0:X_R-1][0:W_C-1];
  logic signed [D_W-1:0]   res_c    [0:X_R-1][0:W_C-1];
  logic signed [D_W-1:0]   result_q [0:X_R-1][0:W_C-1];

  // Next-state logic: feed M_DIM vectors, drain the skew, flag done
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_clr_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          state_d     = ST_FEED;
          cnt_d       = '0;
          start_clr_c = 1'b1;
        end
      end
      ST_FEED: begin
        if (cnt_q == CNT_W'(M_DIM - 1)) begin
          cnt_d   = '0;
          state_d = (DRAIN_N == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_N - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    shift_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    busy_d  = shift_d;
    valid_d = (state_d == ST_DONE);
  end

  // PEs and skew lines advance only on shift edges; start or sync reset clears them
  always_comb begin
    en_c     = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    pe_clr_c = start_clr_c || !I_SYNC_RSTN;
    cap_c    = (state_d == ST_DONE);
  end

  // Controller and registered status outputs
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Live operands during FEED, zeros while draining
  always_comb begin
    for (int i = 0; i < X_R; i++) begin
      x_feed_c[i] = (state_q == ST_FEED) ? I_X_VECTOR[i] : '0;
    end
    for (int j = 0; j < W_C; j++) begin
      w_feed_c[j] = (state_q == ST_FEED) ? I_W_VECTOR[j] : '0;
    end
  end

  // X skew: row i delayed by i stages
  for (genvar i = 0; i < X_R; i++) begin : g_xsk
    if (i == 0) begin : g_direct
      assign x_link[0][0] = x_feed_c[0];
    end else begin : g_line
      logic signed [D_W-1:0] sk_q [0:i-1];
      // Shift the row's delay line on each array shift
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
          for (int s = 0; s < i; s++) sk_q[s] <= '0;
        end else if (pe_clr_c) begin
          for (int s = 0; s < i; s++) sk_q[s] <= '0;
        end else if (en_c) begin
          sk_q[0] <= x_feed_c[i];
          for (int s = 1; s < i; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign x_link[i][0] = sk_q[i-1];
    end
  end

  // W skew: column j delayed by j stages
  for (genvar j = 0; j < W_C; j++) begin : g_wsk
    if (j == 0) begin : g_direct
      assign w_link[0][0] = w_feed_c[0];
    end else begin : g_line
      logic signed [D_W-1:0] sk_q [0:j-1];
      // Shift the column's delay line on each array shift
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
          for (int s = 0; s < j; s++) sk_q[s] <= '0;
        end else if (pe_clr_c) begin
          for (int s = 0; s < j; s++) sk_q[s] <= '0;
        end else if (en_c) begin
          sk_q[0] <= w_feed_c[j];
          for (int s = 1; s < j; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign w_link[0][j] = sk_q[j-1];
    end
  end

  // PE grid: x flows right along rows, w flows down columns
  for (genvar i = 0; i < X_R; i++) begin : g_row
    for (genvar j = 0; j < W_C; j++) begin : g_col
      logic signed [D_W-1:0] x_out_c;
      logic signed [D_W-1:0] w_out_c;

      sa_pe #(
        .D_W   (D_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .clr_i       (pe_clr_c),
        .en_i        (en_c),
        .x_i         (x_link[i][j]),
        .w_i         (w_link[i][j]),
        .x_o         (x_out_c),
        .w_o         (w_out_c),
        .acc_nxt_c   (acc_nxt[i][j])
      );

      if (j < W_C - 1) begin : g_xf
        assign x_link[i][j+1] = x_out_c;
      end else begin : g_xe
        logic signed [D_W-1:0] x_unused;
        assign x_unused = x_out_c;
      end

      if (i < X_R - 1) begin : g_wf
        assign w_link[i+1][j] = w_out_c;
      end else begin : g_we
        logic signed [D_W-1:0] w_unused;
        assign w_unused = w_out_c;
      end
    end
  end

  // Reduce each accumulator (including the final update) to output width
  always_comb begin
    for (int i = 0; i < X_R; i++) begin
      for (int j = 0; j < W_C; j++) begin
        res_c[i][j] = D_W'(sat_trunc(SAT_W'(acc_nxt[i][j]), D_W, FRAC));
      end
    end
  end

  // Result matrix captured on the last PE update and held until next start
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      for (int i = 0; i < X_R; i++)
        for (int j = 0; j < W_C; j++) result_q[i][j] <= '0;
    end else if (pe_clr_c) begin
      for (int i = 0; i < X_R; i++)
        for (int j = 0; j < W_C; j++) result_q[i][j] <= '0;
    end else if (cap_c) begin
      for (int i = 0; i < X_R; i++)
        for (int j = 0; j < W_C; j++) result_q[i][j] <= res_c[i][j];
    end
  end

  assign O_PE_SHIFT = shift_q;
  assign O_BUSY     = busy_q;
  assign O_VALID    = valid_q;
  assign O_RESULT   = result_q;

endmodule
